// File: rtl/gan_layer_mac.sv
// Sequential fixed-point dense layer: one time-shared signed multiplier walks all
// neuron/input pairs of a latched input vector and weight matrix, optional ReLU.
module gan_layer_mac #(
  parameter int WIDTH = 32,
  parameter int FRAC  = 24,
  parameter int N_IN  = 2,
  parameter int N_OUT = 3,
  parameter int ACT   = 0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic [N_IN*WIDTH-1:0]         x_in,
  input  logic [N_OUT*N_IN*WIDTH-1:0]   w_in,
  output logic [N_OUT*WIDTH-1:0]        y_out,
  output logic                          busy,
  output logic                          done,
  output logic                          sat
);

  localparam int ACCW = 2*WIDTH + $clog2(N_IN) + 1;
  localparam int IW   = (N_IN  > 1) ? $clog2(N_IN)  : 1;
  localparam int JW   = (N_OUT > 1) ? $clog2(N_OUT) : 1;
  localparam logic signed [ACCW-1:0] MAXV = {{(ACCW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [ACCW-1:0] MINV = ~MAXV;

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_DONE} state_t;

  state_t                         state_q, state_d;
  logic [IW-1:0]                  i_q, i_d;
  logic [JW-1:0]                  j_q, j_d;
  logic signed [ACCW-1:0]         acc_q, acc_d;
  logic [N_IN*WIDTH-1:0]          x_q, x_d;
  logic [N_OUT*N_IN*WIDTH-1:0]    w_q, w_d;
  logic [N_OUT*WIDTH-1:0]         res_q, res_d;
  logic [N_OUT*WIDTH-1:0]         y_q, y_d;
  logic                           sat_q, sat_d;

  logic signed [WIDTH-1:0]        x_sel, w_sel;
  logic signed [2*WIDTH-1:0]      prod;
  logic signed [ACCW-1:0]         acc_next, shifted;
  logic [WIDTH-1:0]               r;
  logic                           clamp;
  int unsigned                    ii, jj;

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    acc_d   = acc_q;
    x_d     = x_q;
    w_d     = w_q;
    res_d   = res_q;
    y_d     = y_q;
    sat_d   = sat_q;

    ii       = 32'(i_q);
    jj       = 32'(j_q);
    x_sel    = x_q[ii*WIDTH +: WIDTH];
    w_sel    = w_q[(jj*N_IN + ii)*WIDTH +: WIDTH];
    prod     = x_sel * w_sel;
    acc_next = acc_q + ACCW'(prod);
    // Floor rounding via arithmetic shift, then clamp, then ReLU.
    shifted  = acc_next >>> FRAC;
    clamp    = 1'b0;
    if (shifted > MAXV) begin
      r     = MAXV[WIDTH-1:0];
      clamp = 1'b1;
    end else if (shifted < MINV) begin
      r     = MINV[WIDTH-1:0];
      clamp = 1'b1;
    end else begin
      r = shifted[WIDTH-1:0];
    end
    if (ACT == 1 && r[WIDTH-1]) r = '0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          x_d     = x_in;
          w_d     = w_in;
          i_d     = '0;
          j_d     = '0;
          acc_d   = '0;
          sat_d   = 1'b0;
          state_d = S_MAC;
        end
      end
      S_MAC: begin
        if (i_q != IW'(N_IN-1)) begin
          acc_d = acc_next;
          i_d   = i_q + 1'b1;
        end else begin
          res_d[jj*WIDTH +: WIDTH] = r;
          sat_d = sat_q | clamp;
          acc_d = '0;
          i_d   = '0;
          if (j_q == JW'(N_OUT-1)) begin
            y_d     = res_d;
            state_d = S_DONE;
          end else begin
            j_d = j_q + 1'b1;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      i_q     <= '0;
      j_q     <= '0;
      acc_q   <= '0;
      x_q     <= '0;
      w_q     <= '0;
      res_q   <= '0;
      y_q     <= '0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      acc_q   <= acc_d;
      x_q     <= x_d;
      w_q     <= w_d;
      res_q   <= res_d;
      y_q     <= y_d;
      sat_q   <= sat_d;
    end
  end

  assign y_out = y_q;
  assign busy  = (state_q == S_MAC);
  assign done  = (state_q == S_DONE);
  assign sat   = sat_q;

endmodule

// File: tb/tb_gan_layer_mac.sv
// Directed bench for gan_layer_mac: identity instance plus a ReLU instance on shared inputs.
module tb_gan_layer_mac;

  logic         clk, rst_n, start;
  logic [63:0]  x_in;
  logic [191:0] w_in;
  logic [95:0]  y_out, y_r;
  logic         busy, done, sat, busy_r, done_r, sat_r;
  int           n_checks = 0;
  int           n_fail   = 0;

  gan_layer_mac dut (
    .clk(clk), .rst_n(rst_n), .start(start), .x_in(x_in), .w_in(w_in),
    .y_out(y_out), .busy(busy), .done(done), .sat(sat)
  );

  gan_layer_mac #(.ACT(1)) dut_r (
    .clk(clk), .rst_n(rst_n), .start(start), .x_in(x_in), .w_in(w_in),
    .y_out(y_r), .busy(busy_r), .done(done_r), .sat(sat_r)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Called at posedge+1 in IDLE; pulses start and follows the run to one edge past done.
  task automatic do_run(input logic [63:0] x, input logic [191:0] w,
                        output int busy_cnt, output int done_at, output int done_cnt);
    x_in = x; w_in = w; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    busy_cnt = 0; done_at = -1; done_cnt = 0;
    for (int k = 0; k < 20; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      if (busy) busy_cnt++;
      if (done) begin done_cnt++; if (done_at < 0) done_at = k; end
      if (done_at >= 0 && k >= done_at + 1) break;
    end
  endtask

  task automatic test_reset();
    #2;
    n_checks++; if (y_out !== 96'h0) begin n_fail++; $display("FAIL reset_y got=%h exp=0", y_out); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", done); end
    n_checks++; if (sat !== 1'b0) begin n_fail++; $display("FAIL reset_sat got=%b exp=0", sat); end
  endtask

  task automatic test_basic();
    int bc, da, dc;
    do_run({2{32'h01000000}}, {6{32'h01000000}}, bc, da, dc);
    n_checks++; if (y_out !== {3{32'h02000000}}) begin n_fail++; $display("FAIL basic_y got=%h exp=%h", y_out, {3{32'h02000000}}); end
    n_checks++; if (y_r !== {3{32'h02000000}}) begin n_fail++; $display("FAIL basic_y_relu got=%h exp=%h", y_r, {3{32'h02000000}}); end
    n_checks++; if (bc !== 6) begin n_fail++; $display("FAIL basic_busy_cycles got=%0d exp=6", bc); end
    n_checks++; if (da !== 6) begin n_fail++; $display("FAIL basic_done_edge got=%0d exp=6", da); end
    n_checks++; if (dc !== 1) begin n_fail++; $display("FAIL basic_done_count got=%0d exp=1", dc); end
    n_checks++; if (sat !== 1'b0) begin n_fail++; $display("FAIL basic_sat got=%b exp=0", sat); end
  endtask

  task automatic test_sign_relu();
    int bc, da, dc;
    do_run({32'hFF000000, 32'h00000000}, {6{32'h00800000}}, bc, da, dc);
    n_checks++; if (y_out !== {3{32'hFF800000}}) begin n_fail++; $display("FAIL sign_y got=%h exp=%h", y_out, {3{32'hFF800000}}); end
    n_checks++; if (y_r !== 96'h0) begin n_fail++; $display("FAIL relu_y got=%h exp=0", y_r); end
    n_checks++; if (sat !== 1'b0) begin n_fail++; $display("FAIL sign_sat got=%b exp=0", sat); end
  endtask

  task automatic test_saturation();
    int bc, da, dc;
    do_run({2{32'h7F000000}}, {6{32'h7F000000}}, bc, da, dc);
    n_checks++; if (y_out !== {3{32'h7FFFFFFF}}) begin n_fail++; $display("FAIL sat_pos_y got=%h exp=%h", y_out, {3{32'h7FFFFFFF}}); end
    n_checks++; if (sat !== 1'b1) begin n_fail++; $display("FAIL sat_pos_flag got=%b exp=1", sat); end
    do_run({2{32'h7F000000}}, {6{32'h81000000}}, bc, da, dc);
    n_checks++; if (y_out !== {3{32'h80000000}}) begin n_fail++; $display("FAIL sat_neg_y got=%h exp=%h", y_out, {3{32'h80000000}}); end
    n_checks++; if (sat !== 1'b1) begin n_fail++; $display("FAIL sat_neg_flag got=%b exp=1", sat); end
    n_checks++; if (y_r !== 96'h0) begin n_fail++; $display("FAIL sat_neg_relu got=%h exp=0", y_r); end
    n_checks++; if (sat_r !== 1'b1) begin n_fail++; $display("FAIL sat_neg_relu_flag got=%b exp=1", sat_r); end
    do_run({2{32'h01000000}}, {6{32'h01000000}}, bc, da, dc);
    n_checks++; if (sat !== 1'b0) begin n_fail++; $display("FAIL sat_cleared got=%b exp=0", sat); end
  endtask

  task automatic test_floor();
    int bc, da, dc;
    do_run({32'h00000000, 32'h00000001}, {6{32'h00800000}}, bc, da, dc);
    n_checks++; if (y_out !== 96'h0) begin n_fail++; $display("FAIL floor_pos got=%h exp=0", y_out); end
    do_run({32'h00000000, 32'hFFFFFFFF}, {6{32'h00800000}}, bc, da, dc);
    n_checks++; if (y_out !== {3{32'hFFFFFFFF}}) begin n_fail++; $display("FAIL floor_neg got=%h exp=%h", y_out, {3{32'hFFFFFFFF}}); end
  endtask

  task automatic test_back_to_back();
    int cnt, first, second;
    cnt = 0; first = -1; second = -1;
    x_in = {2{32'h01000000}}; w_in = {6{32'h01000000}}; start = 1'b1;
    for (int k = 0; k < 24; k++) begin
      @(posedge clk); #1;
      if (done) begin
        cnt++;
        if (first < 0) first = k; else if (second < 0) second = k;
      end
    end
    start = 1'b0;
    n_checks++; if (cnt !== 3) begin n_fail++; $display("FAIL b2b_done_count got=%0d exp=3", cnt); end
    n_checks++; if (first !== 6) begin n_fail++; $display("FAIL b2b_first_done got=%0d exp=6", first); end
    n_checks++; if (second - first !== 8) begin n_fail++; $display("FAIL b2b_period got=%0d exp=8", second - first); end
    repeat (3) @(posedge clk); #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_idle_busy got=%b exp=0", busy); end
  endtask

  task automatic test_latch_and_ignore();
    int dc, da, bc;
    logic [95:0] exp_y;
    exp_y = {32'h04000000, 32'h03000000, 32'h02000000};
    x_in = {32'h00800000, 32'h01000000};
    w_in = {32'h02000000, 32'h03000000, 32'h02000000, 32'h02000000, 32'h02000000, 32'h01000000};
    start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    dc = 0; da = -1; bc = 0;
    for (int k = 0; k < 12; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      if (k == 2) begin x_in = '1; w_in = {6{32'h40000000}}; end
      start = (k == 3);
      if (busy) bc++;
      if (done) begin dc++; if (da < 0) da = k; end
    end
    start = 1'b0;
    n_checks++; if (y_out !== exp_y) begin n_fail++; $display("FAIL latch_y got=%h exp=%h", y_out, exp_y); end
    n_checks++; if (y_r !== exp_y) begin n_fail++; $display("FAIL latch_y_relu got=%h exp=%h", y_r, exp_y); end
    n_checks++; if (dc !== 1) begin n_fail++; $display("FAIL ignore_start_done_count got=%0d exp=1", dc); end
    n_checks++; if (bc !== 6) begin n_fail++; $display("FAIL ignore_start_busy got=%0d exp=6", bc); end
    n_checks++; if (da !== 6) begin n_fail++; $display("FAIL latch_done_edge got=%0d exp=6", da); end
  endtask

  task automatic test_reset_midrun();
    int bc, da, dc;
    logic saw_done;
    x_in = {2{32'h01000000}}; w_in = {6{32'h01000000}}; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (2) @(posedge clk);
    #1; rst_n = 1'b0; #1;
    n_checks++; if (y_out !== 96'h0) begin n_fail++; $display("FAIL midrst_y got=%h exp=0", y_out); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy got=%b exp=0", busy); end
    saw_done = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (done) saw_done = 1'b1;
      if (k == 2) rst_n = 1'b1;
    end
    n_checks++; if (saw_done !== 1'b0) begin n_fail++; $display("FAIL midrst_no_done got=%b exp=0", saw_done); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_no_restart got=%b exp=0", busy); end
    do_run({2{32'h01000000}}, {6{32'h01000000}}, bc, da, dc);
    n_checks++; if (y_out !== {3{32'h02000000}}) begin n_fail++; $display("FAIL midrst_rerun_y got=%h exp=%h", y_out, {3{32'h02000000}}); end
    n_checks++; if (da !== 6) begin n_fail++; $display("FAIL midrst_rerun_done got=%0d exp=6", da); end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; x_in = '0; w_in = '0;
    test_reset();
    repeat (2) @(posedge clk);
    #1; rst_n = 1'b1;
    @(posedge clk); #1;
    test_basic();
    test_sign_relu();
    test_saturation();
    test_floor();
    test_back_to_back();
    test_latch_and_ignore();
    test_reset_midrun();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
